// File: rtl/fifo_pkg.sv
// fifo_pkg: arbiter state encodings and FIFO sizing constants shared by the FIFO blocks.
package fifo_pkg;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        GNT0      = 2'b01,
        GNT1      = 2'b10,
        FULL_WAIT = 2'b11
    } arb_state_t;
endpackage

// File: rtl/fifo_wr_arb_if.sv
// fifo_wr_arb_if: producer requests, FIFO write bus and debug stall counters of the write arbiter.
interface fifo_wr_arb_if #(parameter int DATA_WIDTH = 32);
    import fifo_pkg::*;
    logic                  req0, req1;
    logic [DATA_WIDTH-1:0] d0, d1;
    logic [CNT_W-1:0]      data_count;
    logic                  gnt0, gnt1, fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_din;
    logic [7:0]            stall0, stall1;
    modport master (
        output req0, req1, d0, d1, data_count,
        input  gnt0, gnt1, fifo_wr_en, fifo_din, stall0, stall1
    );
    modport slave (
        input  req0, req1, d0, d1, data_count,
        output gnt0, gnt1, fifo_wr_en, fifo_din, stall0, stall1
    );
endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker; on a tie the requester that did not win last time is chosen.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick_valid,
    output logic pick_idx
);
    assign pick_valid = req0 | req1;
    assign pick_idx   = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write arbiter for two producers, throttled by FIFO occupancy.
module fifo_wr_arb
    import fifo_pkg::*;
(
    input logic          clk,
    input logic          reset_n,
    fifo_wr_arb_if.slave bus
);
    arb_state_t   state_q, state_d;
    logic         last_q, pick_valid, pick_idx, space;
    logic [7:0]   stall0_q, stall0_d, stall1_q, stall1_d;
    logic [CNT_W:0] occ;
    rr_pick2 u_pick (
        .req0      (bus.req0),
        .req1      (bus.req1),
        .last      (last_q),
        .pick_valid(pick_valid),
        .pick_idx  (pick_idx)
    );
    // the write currently on the bus lands on the same edge data_count is updated
    assign occ   = {1'b0, bus.data_count} + {{CNT_W{1'b0}}, bus.fifo_wr_en};
    assign space = occ < (CNT_W+1)'(DEPTH);
    always_comb begin
        state_d  = !pick_valid ? IDLE : !space ? FULL_WAIT : pick_idx ? GNT1 : GNT0;
        stall0_d = stall0_q + {7'd0, state_d == FULL_WAIT && bus.req0 && stall0_q != 8'hff};
        stall1_d = stall1_q + {7'd0, state_d == FULL_WAIT && bus.req1 && stall1_q != 8'hff};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            bus.fifo_din <= '0;
            stall0_q     <= '0;
            stall1_q     <= '0;
        end else begin
            state_q  <= state_d;
            stall0_q <= stall0_d;
            stall1_q <= stall1_d;
            if (state_d == GNT0 || state_d == GNT1) begin
                last_q       <= pick_idx;
                bus.fifo_din <= pick_idx ? bus.d1 : bus.d0;
            end
        end
    end
    assign bus.gnt0       = state_q == GNT0;
    assign bus.gnt1       = state_q == GNT1;
    assign bus.fifo_wr_en = state_q == GNT0 || state_q == GNT1;
    assign bus.stall0     = stall0_q;
    assign bus.stall1     = stall1_q;
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: randomized producers and FIFO occupancy checked against a cycle-level reference model.
module tb_fifo_wr_arb;
    import fifo_pkg::*;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;
    fifo_wr_arb_if #(.DATA_WIDTH(32)) bus ();
    fifo_wr_arb dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    int n_tests, n_fail;
    bit r0, r1, rd, last_w;
    bit o_g0, o_g1, o_wr, e_g0, e_g1, e_wr;
    logic [31:0] o_din, e_din;
    int s0, s1, cnt, o_st0, o_st1, e_st0, e_st1;
    function automatic logic [31:0] word(bit x, int s);
        return {x ? 8'hB1 : 8'hA0, 24'(s)};
    endfunction
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic drive();
        bus.req0 = r0;
        bus.req1 = r1;
        bus.d0 = word(1'b0, s0);
        bus.d1 = word(1'b1, s1);
        bus.data_count = 4'(cnt);
    endtask
    task automatic model_reset();
        {o_g0, o_g1, o_wr, rd} = '0;
        o_din = '0;
        o_st0 = 0;
        o_st1 = 0;
        last_w = 1'b1;
    endtask
    // outcome of the coming edge: occupancy including the write in flight decides grant vs stall
    task automatic predict();
        bit w;
        e_st0 = o_st0;
        e_st1 = o_st1;
        {e_g0, e_g1, e_wr} = '0;
        e_din = o_din;
        if (r0 || r1) begin
            if (cnt + int'(o_wr) >= DEPTH) begin
                if (r0 && e_st0 < 255) e_st0++;
                if (r1 && e_st1 < 255) e_st1++;
            end else begin
                w = (r0 && r1) ? !last_w : r1;
                last_w = w;
                e_g0 = !w;
                e_g1 = w;
                e_wr = 1'b1;
                e_din = word(w, w ? s1 : s0);
            end
        end
    endtask
    task automatic tick(int p0, int p1, int prd);
        @(posedge clk);
        #1;
        if (o_wr) cnt++;
        if (rd) cnt--;
        {o_g0, o_g1, o_wr} = {e_g0, e_g1, e_wr};
        o_din = e_din;
        o_st0 = e_st0;
        o_st1 = e_st1;
        check("gnt0", 32'(bus.gnt0), 32'(o_g0));
        check("gnt1", 32'(bus.gnt1), 32'(o_g1));
        check("wr_en", 32'(bus.fifo_wr_en), 32'(o_wr));
        check("din", bus.fifo_din, o_din);
        check("stall0", 32'(bus.stall0), 32'(o_st0));
        check("stall1", 32'(bus.stall1), 32'(o_st1));
        if (o_g0) s0++;
        if (o_g1) s1++;
        if (o_g0 || !r0) r0 = int'($urandom_range(99)) < p0;
        if (o_g1 || !r1) r1 = int'($urandom_range(99)) < p1;
        rd = cnt > 0 && int'($urandom_range(99)) < prd;
        drive();
        predict();
    endtask
    initial begin
        int k;
        n_tests = 0;
        n_fail = 0;
        s0 = 0;
        s1 = 0;
        cnt = 0;
        r0 = 1'b1;
        r1 = 1'b1;
        model_reset();
        drive();
        #1 reset_n = 1'b0;
        #2;
        check("rst_gnt0", 32'(bus.gnt0), 0);
        check("rst_gnt1", 32'(bus.gnt1), 0);
        check("rst_wr_en", 32'(bus.fifo_wr_en), 0);
        check("rst_din", bus.fifo_din, 0);
        check("rst_stall0", 32'(bus.stall0), 0);
        check("rst_stall1", 32'(bus.stall1), 0);
        #9 reset_n = 1'b1;
        predict();
        repeat (8) tick(100, 100, 100);
        repeat (6) tick(0, 0, 100);
        repeat (4) tick(0, 100, 0);
        repeat (10) tick(100, 0, 0);
        repeat (300) tick(100, 100, 0);
        check("stall0_sat", 32'(bus.stall0), 255);
        check("stall1_sat", 32'(bus.stall1), 255);
        repeat (40) tick(100, 100, 10);
        repeat (500) tick(60, 60, 45);
        repeat (200) tick(90, 90, 80);
        k = 0;
        while (!o_g1 && k < 50) begin
            tick(100, 100, 100);
            k++;
        end
        check("pre_rst_gnt1", 32'(bus.gnt1), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_gnt1", 32'(bus.gnt1), 0);
        check("async_wr_en", 32'(bus.fifo_wr_en), 0);
        check("async_stall0", 32'(bus.stall0), 0);
        model_reset();
        cnt = 0;
        r0 = 1'b1;
        r1 = 1'b1;
        drive();
        @(negedge clk);
        reset_n = 1'b1;
        predict();
        tick(100, 100, 100);
        check("tie_after_rst", 32'(bus.gnt0), 1);
        repeat (6) tick(100, 100, 100);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Two-requester round-robin write arbiter for the 8-deep FIFO. It sits between two independent producers and the single FIFO write port. Each cycle it grants at most one producer, registers that producer's data onto the FIFO write bus, and throttles writes using the FIFO's `data_count` so the FIFO never enters its write-error state. Each producer has a saturating stall counter for debug.

## Interface
- `DATA_WIDTH`, 32, width of producer and FIFO data
- `DEPTH`, 8, FIFO capacity; `data_count` is `$clog2(DEPTH)+1` bits wide
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req0`, `req1`  in  1 each  producer write requests
- `d0`, `d1`  in  DATA_WIDTH each  producer data, valid while the matching `req` is high
- `data_count`  in  4  FIFO occupancy, 0..8
- `gnt0`, `gnt1`  out  1 each  registered grant; high in the cycle the granted word is on `fifo_din`
- `fifo_wr_en`  out  1  registered write strobe to the FIFO
- `fifo_din`  out  DATA_WIDTH  registered write data
- `stall0`, `stall1`  out  8 each  saturating count of cycles the requester was refused for lack of space

## Operation
- States (encoded in the shared package): IDLE=2'b00, GNT0=2'b01, GNT1=2'b10, FULL_WAIT=2'b11. The state is registered.
- Space check: `space = (data_count + fifo_wr_en) < DEPTH`.
  - The FIFO updates `data_count` on the same edge that accepts `fifo_wr_en`, so the in-flight write must be counted.
- Next-state rule, identical from every state and evaluated each cycle:
  - No `req` → IDLE.
  - Any `req` and `!space` → FULL_WAIT.
  - Exactly one `req` and `space` → GNT of that requester.
  - Both `req` and `space` → GNT of the requester other than `last`.
- `last` is a 1-bit register. It is updated to the granted index on every entry to GNT0 or GNT1, and is unchanged otherwise.
- Outputs decoded from the registered state:
  - GNT0: `gnt0`=1, `fifo_wr_en`=1.
  - GNT1: `gnt1`=1, `fifo_wr_en`=1.
  - IDLE and FULL_WAIT: all grants and `fifo_wr_en` = 0.
- `fifo_din` is loaded with `d0` or `d1` on the edge that enters GNT0 or GNT1. It holds its value otherwise.
- Stall counters: on each edge that enters FULL_WAIT, `stallX` increments for each X with `reqX`=1. Counters saturate at 255.
- Back-to-back grants to the same requester are permitted when the other requester is idle (streaming at one word per cycle).

## Timing
- Latency: `req` sampled at edge k → `gntX`, `fifo_wr_en`, and `fifo_din` valid in cycle k..k+1 → FIFO captures at edge k+1.
- Producer handshake:
  - A producer holds `req` and `d` stable until it sees its `gnt`.
  - A `req` still high during a cycle with its own `gnt`=1 is a new word, so `d` must already present the next word.
- Fairness: with both requests continuously high and space available, grants strictly alternate. Maximum wait is 1 grant slot.
- Full boundary: with `data_count`=7 and `fifo_wr_en`=1, the next state is FULL_WAIT. No write is ever issued at `data_count`=8.
- Leaving FULL_WAIT: the first cycle in which `space` is true (after a FIFO read lowers `data_count`), the pending requester(s) are granted per round-robin.
- Reset (asynchronous, also mid-operation):
  - Immediately: state=IDLE, `gnt0`/`gnt1`/`fifo_wr_en`=0, `fifo_din`=0, `stall0`/`stall1`=0, `last`=1 (so `req0` wins the first tie).
  - Any in-flight write is dropped without being retried.

## Structure
- Package `fifo_pkg`:
  - State encodings IDLE/GNT0/GNT1/FULL_WAIT.
  - `DEPTH` default 8 and the `data_count` width constant, shared with the FIFO blocks.
- Sub-module `rr_pick2`: combinational 2-way round-robin picker.
  - Inputs: `req0`, `req1`, `last`.
  - Outputs: `pick_valid`, `pick_idx`.
- Registered state, `last`, data mux, and stall counters live in the top module.

## Test plan
- Reset with `req0`=`req1`=1, `data_count`=0, then release → first grant is `gnt0` with `fifo_din`=`d0`, then `gnt1`, `gnt0`, … alternating every cycle.
- Only `req1` held high for 4 cycles with `data_count` tracking the writes from 0 → 4 consecutive `gnt1` pulses and 4 FIFO writes, with no bubble.
- `data_count`=7, `req0` held → one write, then FULL_WAIT. `stall0` increments each cycle; `fifo_wr_en` stays 0 while `data_count`=8.
- From FULL_WAIT with both requests high, `data_count` drops 8→7 → exactly one grant, going to the requester opposite `last`, then FULL_WAIT again.
- Hold both requests with `data_count`=8 for 300 cycles → `stall0`=`stall1`=255 (saturated, no wrap).
- Assert `reset_n`=0 in the middle of a GNT1 cycle → `gnt1` and `fifo_wr_en` fall without waiting for a clock edge; after release, `req0` wins the first tie.
